control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 32 +++
 rtl/control_sequencer_classifier.sv | 20 ++
 rtl/control_sequencer.sv | 151 +++++++++++++++
 tb/tb_control_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared opcode map, FSM state encoding and instruction classes for the
// control sequencer and its opcode classifier.
package control_sequencer_pkg;

  localparam logic [5:0] OP_MOVI   = 6'h00;
  localparam logic [5:0] OP_MOV    = 6'h01;
  localparam logic [5:0] OP_LOAD   = 6'h02;
  localparam logic [5:0] OP_STORE  = 6'h03;
  localparam logic [5:0] OP_ALU_LO = 6'h04;
  localparam logic [5:0] OP_ALU_HI = 6'h10;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_STOP
  } state_e;

  typedef enum logic [2:0] {
    CL_MOVI,
    CL_MOV,
    CL_LOAD,
    CL_STORE,
    CL_ALU,
    CL_HALT,
    CL_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/control_sequencer_classifier.sv
// Purely combinational opcode -> instruction class map; anything not
// recognised falls through to CL_ILLEGAL.
module opcode_classifier
  import control_sequencer_pkg::*;
(
  input  logic [5:0] opcode_i,
  output iclass_e    class_o
);

  always_comb begin
    class_o = CL_ILLEGAL;
    if (opcode_i == OP_MOVI)                                class_o = CL_MOVI;
    else if (opcode_i == OP_MOV)                            class_o = CL_MOV;
    else if (opcode_i == OP_LOAD)                           class_o = CL_LOAD;
    else if (opcode_i == OP_STORE)                          class_o = CL_STORE;
    else if (opcode_i >= OP_ALU_LO && opcode_i <= OP_ALU_HI) class_o = CL_ALU;
    else if (opcode_i == OP_HALT)                           class_o = CL_HALT;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: drives instruction fetch,
// ALU handshake, data memory access and register-file write strobes.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   pc,
  input  logic              imem_valid,
  input  logic [31:0]       instr_i,
  output logic [31:0]       ir,
  output logic              alu_start,
  output logic [5:0]        alu_op,
  input  logic              alu_done,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_valid,
  output logic              rf_we2,
  output logic              rf_we1,
  output logic              imm_sel,
  output logic              halt,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              halt_q, halt_d;
  logic              illegal_q, illegal_d;
  logic              started_q, started_d;
  iclass_e           cls;

  logic imem_req_c, alu_start_c, dmem_req_c, dmem_we_c;
  logic rf_we2_c, rf_we1_c, imm_sel_c;

  opcode_classifier u_cls (
    .opcode_i (ir_q[31:26]),
    .class_o  (cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    halt_d      = halt_q;
    illegal_d   = illegal_q;
    started_d   = 1'b0;
    imem_req_c  = 1'b0;
    alu_start_c = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    rf_we2_c    = 1'b0;
    rf_we1_c    = 1'b0;
    imm_sel_c   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_valid) begin
          ir_d    = instr_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        unique case (cls)
          CL_MOVI, CL_MOV:   state_d = ST_WB;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_ALU:            state_d = ST_EXEC;
          CL_HALT: begin
            state_d = ST_STOP;
            halt_d  = 1'b1;
          end
          default: begin
            state_d   = ST_STOP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        // started_q marks that the single start pulse has gone out
        alu_start_c = ~started_q;
        started_d   = 1'b1;
        if (alu_done) begin
          started_d = 1'b0;
          state_d   = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls == CL_STORE);
        if (dmem_valid) begin
          if (cls == CL_STORE) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we2_c  = 1'b1;
        rf_we1_c  = (cls == CL_ALU);
        imm_sel_c = (cls == CL_MOVI);
        pc_d      = pc_q + PC_W'(1);
        state_d   = ST_FETCH;
      end
      ST_STOP: ;
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes are masked while rst is high so an abandoned transaction
  // issues nothing in the reset cycle itself.
  assign imem_req  = imem_req_c  & ~rst;
  assign alu_start = alu_start_c & ~rst;
  assign dmem_req  = dmem_req_c  & ~rst;
  assign dmem_we   = dmem_we_c   & ~rst;
  assign rf_we2    = rf_we2_c    & ~rst;
  assign rf_we1    = rf_we1_c    & ~rst;
  assign imm_sel   = imm_sel_c   & ~rst;

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign halt      = halt_q;
  assign illegal   = illegal_q;
  assign alu_op    = (state_q == ST_EXEC) ? ir_q[31:26] : 6'd0;
  assign dmem_addr = (cls == CL_STORE) ? ADDR_W'(ir_q[25:18]) : ADDR_W'(ir_q[7:0]);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: each issued instruction pushes its expected memory and
// write-back events; a negedge monitor pops and compares them.
module tb_control_sequencer;

  localparam int PC_W   = 8;
  localparam int ADDR_W = 9;

  typedef struct packed {
    logic            is_mem;
    logic            we1;
    logic            imm;
    logic            we;
    logic [8:0]      addr;
    logic [PC_W-1:0] pc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [PC_W-1:0]   pc;
  logic              imem_valid;
  logic [31:0]       instr_i;
  logic [31:0]       ir;
  logic              alu_start;
  logic [5:0]        alu_op;
  logic              alu_done;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_valid;
  logic              rf_we2, rf_we1, imm_sel, halt, illegal;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_astart = 0;
  int leak  = 0;
  int last_wb = 0;
  logic [5:0] last_alu_op = '0;

  int imem_dly = 0, dmem_dly = 0, alu_dly = 0;
  bit stray = 0, stray_all = 0;
  int icnt = 0, dcnt = 0, acnt = 0;
  bit abusy = 0, tog = 0;

  logic [31:0]     instr_q[$];
  exp_t            exp_q[$];
  logic [PC_W-1:0] exp_pc = '0;
  exp_t            mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_sequencer #(.PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .pc(pc), .imem_valid(imem_valid), .instr_i(instr_i), .ir(ir),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_valid(dmem_valid),
    .rf_we2(rf_we2), .rf_we1(rf_we1), .imm_sel(imm_sel), .halt(halt), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of what the sequencer must emit for one instruction.
  task automatic push_instr(input logic [31:0] ins);
    logic [5:0] op;
    exp_t e;
    op = ins[31:26];
    instr_q.push_back(ins);
    e = '0;
    e.pc = exp_pc;
    if (op == 6'h02 || op == 6'h03) begin
      e.is_mem = 1'b1;
      e.we     = (op == 6'h03);
      e.addr   = (op == 6'h03) ? {1'b0, ins[25:18]} : {1'b0, ins[7:0]};
      exp_q.push_back(e);
      e.is_mem = 1'b0; e.we = 1'b0; e.addr = '0;
    end
    if (op == 6'h00 || op == 6'h01 || op == 6'h02 || (op >= 6'h04 && op <= 6'h10)) begin
      e.we1 = (op >= 6'h04);
      e.imm = (op == 6'h00);
      exp_q.push_back(e);
    end
    if (op <= 6'h10) exp_pc = exp_pc + 1'b1;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || instr_q.size() != 0); i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_halt", halt, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0;
    exp_pc = '0;
  endtask

  // Memory / ALU responders: inputs change 1 time unit after the edge.
  initial begin
    imem_valid = 1'b0; instr_i = '0; alu_done = 1'b0; dmem_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      imem_valid = 1'b0;
      if (stray) begin
        tog = ~tog;
        imem_valid = tog;
        instr_i = 32'h0000_0001;
      end else if (imem_req && instr_q.size() > 0) begin
        if (icnt == imem_dly) begin
          imem_valid = 1'b1;
          instr_i = instr_q.pop_front();
          icnt = 0;
        end else icnt++;
      end else icnt = 0;
      dmem_valid = 1'b0;
      if (dmem_req) begin
        if (dcnt == dmem_dly) begin dmem_valid = 1'b1; dcnt = 0; end
        else dcnt++;
      end else dcnt = 0;
      alu_done = 1'b0;
      if (alu_start) begin acnt = 0; abusy = 1'b1; end
      if (abusy) begin
        if (acnt == alu_dly) begin alu_done = 1'b1; abusy = 1'b0; end
        else acnt++;
      end
      if (stray_all) begin dmem_valid = 1'b1; alu_done = 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (alu_start) begin n_astart++; last_alu_op = alu_op; end
    if ((halt || illegal) && (imem_req | dmem_req | dmem_we | alu_start | rf_we1 | rf_we2)) leak++;
    if (rf_we2 || (dmem_req && dmem_valid)) begin
      if (exp_q.size() == 0) chk("sb_unexpected_evt", exp_q.size(), 1);
      else begin
        mon_e = exp_q.pop_front();
        chk("evt_kind", {31'd0, dmem_req && dmem_valid}, {31'd0, mon_e.is_mem});
        chk("evt_pc", pc, mon_e.pc);
        if (mon_e.is_mem) begin
          chk("dmem_we", dmem_we, mon_e.we);
          chk("dmem_addr", dmem_addr, mon_e.addr);
          chk("mem_no_rfwe", rf_we1 | rf_we2, 0);
        end else begin
          chk("rf_we1", rf_we1, mon_e.we1);
          chk("imm_sel", imm_sel, mon_e.imm);
          chk("wb_no_dmem", dmem_req, 0);
          last_wb = cyc;
        end
      end
    end
  end

  initial begin
    int rel, t0, a0, n;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_halt", halt, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_strobes", {alu_start, dmem_req, rf_we1, rf_we2}, 0);

    rst = 1'b0;
    rel = cyc + 1;
    push_instr(32'h0020_1234);
    wait_drain(20);
    chk("movi_lat", last_wb - rel, 2);
    chk("pc_after_movi", pc, exp_pc);

    alu_dly = 5; a0 = n_astart; t0 = cyc + 1;
    push_instr(32'h1000_0000);
    wait_drain(40);
    chk("alu_start_count", n_astart - a0, 1);
    chk("alu_lat_d5", last_wb - t0, 8);
    chk("alu_op", last_alu_op, 6'h04);

    alu_dly = 0; t0 = cyc + 1;
    push_instr(32'h1000_0000);
    wait_drain(20);
    chk("alu_lat_min", last_wb - t0, 3);

    dmem_dly = 2;
    push_instr(32'h0C00_0003);
    wait_drain(20);
    chk("pc_after_store", pc, exp_pc);
    dmem_dly = 0;
    push_instr(32'h0D68_0000);
    wait_drain(20);
    t0 = cyc + 1;
    push_instr(32'h0800_00A5);
    wait_drain(20);
    chk("load_lat", last_wb - t0, 3);
    push_instr(32'h0400_0000);
    push_instr(32'h4000_0000);
    wait_drain(40);

    stray_all = 1'b1;
    repeat (5) @(negedge clk);
    stray_all = 1'b0;
    chk("stray_pc", pc, exp_pc);
    chk("stray_fetch", imem_req, 1);

    n = (1 << PC_W) - int'(exp_pc);
    for (int i = 0; i < n; i++) push_instr({16'h0000, 16'(i)});
    wait_drain(n * 5 + 20);
    chk("pc_wrap", pc, 0);

    push_instr(32'h0000_0042);
    wait_drain(20);
    dmem_dly = 1000;
    instr_q.push_back(32'h0800_0011);
    for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
    chk("mem_wait_seen", dmem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_cycle_dmem_req", dmem_req, 0);
    @(negedge clk);
    chk("midrst_pc", pc, 0);
    chk("midrst_ir", ir, 0);
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_rf_we2", rf_we2, 0);
    rst = 1'b0; exp_pc = '0; dmem_dly = 0;
    #1;
    chk("midrst_fetch", imem_req, 1);

    @(negedge clk);
    push_instr(32'hFC00_0000);
    for (int i = 0; i < 20 && !halt; i++) @(negedge clk);
    chk("halt_set", halt, 1);
    chk("halt_not_illegal", illegal, 0);
    stray = 1'b1;
    repeat (20) @(negedge clk);
    stray = 1'b0;
    chk("stop_leak", leak, 0);
    chk("stop_pc", pc, exp_pc);
    chk("stop_imem_req", imem_req, 0);
    chk("halt_sticky", halt, 1);

    do_reset();
    push_instr(32'h8000_0000);
    for (int i = 0; i < 20 && !illegal; i++) @(negedge clk);
    chk("illegal_20", illegal, 1);
    chk("illegal_no_halt", halt, 0);

    do_reset();
    push_instr(32'h4400_0000);
    for (int i = 0; i < 20 && !illegal; i++) @(negedge clk);
    chk("illegal_11", illegal, 1);

    do_reset();
    push_instr(32'h0020_0001);
    wait_drain(20);
    chk("pc_after_rst_movi", pc, exp_pc);
    chk("final_leak", leak, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
